// File: rtl/dds_hop_pkg.sv
// Shared types and constants for the DDS frequency-hop scheduler.
package dds_hop_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UPD,
    ST_DWELL
  } state_t;

  localparam int         MIN_GAP     = 16;
  localparam int         IOUD_W      = 2;
  localparam logic [2:0] MODE_SINGLE = 3'b000;
  localparam int         FTW_W       = 48;
  localparam int         PTW_W       = 14;
endpackage

// File: rtl/dds_hop_table.sv
// Profile table: one registered write port, one combinational read port.
module dds_hop_table
  import dds_hop_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [FTW_W-1:0]   wr_ftw,
  input  logic [PTW_W-1:0]   wr_ptw,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [AW-1:0]      rd_addr,
  output logic [FTW_W-1:0]   rd_ftw,
  output logic [PTW_W-1:0]   rd_ptw,
  output logic [DWELL_W-1:0] rd_dwell
);
  logic [FTW_W-1:0]   ftw_mem   [DEPTH];
  logic [PTW_W-1:0]   ptw_mem   [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      ftw_mem[wr_addr]   <= wr_ftw;
      ptw_mem[wr_addr]   <= wr_ptw;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  assign rd_ftw   = ftw_mem[rd_addr];
  assign rd_ptw   = ptw_mem[rd_addr];
  assign rd_dwell = dwell_mem[rd_addr];
endmodule

// File: rtl/dds_hop_scheduler.sv
// Frequency-hop sequencer: loads each profile entry into the DDS config
// writer, pulses IOUD, dwells, then advances (optionally looping).
module dds_hop_scheduler
  import dds_hop_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int DWELL_W = 24,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               TBL_WE,
  input  logic [AW-1:0]      TBL_ADDR,
  input  logic [FTW_W-1:0]   TBL_FTW,
  input  logic [PTW_W-1:0]   TBL_PTW,
  input  logic [DWELL_W-1:0] TBL_DWELL,
  input  logic               START,
  input  logic               STOP,
  input  logic [AW:0]        NUM,
  input  logic               LOOP,
  output logic               CFG_CEN,
  output logic [15:0]        CFG_F1H,
  output logic [31:0]        CFG_F1L,
  output logic [PTW_W-1:0]   CFG_PTW1,
  output logic [2:0]         CFG_MODE,
  input  logic               CFG_READY,
  output logic               IOUD,
  output logic               BUSY,
  output logic [AW-1:0]      CUR_IDX,
  output logic               DONE,
  output logic               ERR
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int UW = $clog2(IOUD_W + 1);

  // Short dwells are stretched so the writer sees CEN low long enough to idle.
  function automatic logic [DWELL_W-1:0] gap_dwell(input logic [DWELL_W-1:0] d);
    return (d < DWELL_W'(MIN_GAP)) ? DWELL_W'(MIN_GAP) : d;
  endfunction

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      last_q, last_d;
  logic               cen_q, cen_d;
  logic [15:0]        f1h_q, f1h_d;
  logic [31:0]        f1l_q, f1l_d;
  logic [PTW_W-1:0]   ptw_q, ptw_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [UW-1:0]      ucnt_q, ucnt_d;
  logic               stop_q, stop_d;
  logic               ioud_q, ioud_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [AW-1:0]      rd_addr;
  logic [FTW_W-1:0]   rd_ftw;
  logic [PTW_W-1:0]   rd_ptw;
  logic [DWELL_W-1:0] rd_dwell;
  logic [AW:0]        num_eff;
  logic [AW-1:0]      last_start;
  logic               fetch;

  dds_hop_table #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DWELL_W(DWELL_W)
  ) u_table (
    .clk     (CLK),
    .we      (TBL_WE),
    .wr_addr (TBL_ADDR),
    .wr_ftw  (TBL_FTW),
    .wr_ptw  (TBL_PTW),
    .wr_dwell(TBL_DWELL),
    .rd_addr (rd_addr),
    .rd_ftw  (rd_ftw),
    .rd_ptw  (rd_ptw),
    .rd_dwell(rd_dwell)
  );

  assign num_eff    = (NUM > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : NUM;
  assign last_start = AW'(num_eff - 1'b1);

  // Read address is the entry that would be fetched on this edge.
  always_comb begin
    rd_addr = idx_q;
    if (state_q == ST_IDLE || (state_q == ST_DWELL && idx_q == last_q)) begin
      rd_addr = '0;
    end else if (state_q == ST_DWELL) begin
      rd_addr = idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cen_d   = cen_q;
    f1h_d   = f1h_q;
    f1l_d   = f1l_q;
    ptw_d   = ptw_q;
    dwell_d = dwell_q;
    dcnt_d  = dcnt_q;
    tmo_d   = tmo_q;
    ucnt_d  = ucnt_q;
    stop_d  = stop_q | STOP;
    ioud_d  = ioud_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    fetch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (START && NUM != '0) begin
          fetch   = 1'b1;
          idx_d   = '0;
          last_d  = last_start;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (CFG_READY) begin
          cen_d   = 1'b0;
          ioud_d  = 1'b1;
          ucnt_d  = '0;
          state_d = ST_UPD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cen_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_UPD: begin
        if (ucnt_q == UW'(IOUD_W - 1)) begin
          ioud_d  = 1'b0;
          dcnt_d  = dwell_q;
          state_d = ST_DWELL;
        end else begin
          ucnt_d = ucnt_q + 1'b1;
        end
      end
      ST_DWELL: begin
        if (stop_q || STOP || (dcnt_q <= DWELL_W'(1) && idx_q == last_q && !LOOP)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (dcnt_q <= DWELL_W'(1)) begin
          fetch   = 1'b1;
          idx_d   = rd_addr;
          state_d = ST_LOAD;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fetch) begin
      cen_d   = 1'b1;
      f1h_d   = rd_ftw[FTW_W-1:32];
      f1l_d   = rd_ftw[31:0];
      ptw_d   = rd_ptw;
      dwell_d = gap_dwell(rd_dwell);
      tmo_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      cen_q   <= 1'b0;
      f1h_q   <= '0;
      f1l_q   <= '0;
      ptw_q   <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      tmo_q   <= '0;
      ucnt_q  <= '0;
      stop_q  <= 1'b0;
      ioud_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cen_q   <= cen_d;
      f1h_q   <= f1h_d;
      f1l_q   <= f1l_d;
      ptw_q   <= ptw_d;
      dwell_q <= dwell_d;
      dcnt_q  <= dcnt_d;
      tmo_q   <= tmo_d;
      ucnt_q  <= ucnt_d;
      stop_q  <= stop_d;
      ioud_q  <= ioud_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign CFG_CEN  = cen_q;
  assign CFG_F1H  = f1h_q;
  assign CFG_F1L  = f1l_q;
  assign CFG_PTW1 = ptw_q;
  assign CFG_MODE = MODE_SINGLE;
  assign IOUD     = ioud_q;
  assign BUSY     = busy_q;
  assign CUR_IDX  = idx_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
endmodule

// File: tb/tb_dds_hop_scheduler.sv
// Scoreboard bench for dds_hop_scheduler: stimulus pushes expected events,
// a monitor pops them as CEN windows, DONE pulses and ERR rises appear.
module tb_dds_hop_scheduler;
  localparam int DEPTH = 8, AW = 3, DWELL_W = 24, TIMEOUT = 255;
  localparam int EV_CEN = 0, EV_DONE = 1, EV_ERR = 2;

  typedef struct {
    int          kind;
    int          idx;
    logic [47:0] ftw;
    logic [13:0] ptw;
    int          gap;
  } ev_t;

  logic               CLK, RSTN, TBL_WE, START, STOP, LOOP, CFG_READY;
  logic [AW-1:0]      TBL_ADDR;
  logic [47:0]        TBL_FTW;
  logic [13:0]        TBL_PTW;
  logic [DWELL_W-1:0] TBL_DWELL;
  logic [AW:0]        NUM;
  logic               CFG_CEN, IOUD, BUSY, DONE, ERR;
  logic [15:0]        CFG_F1H;
  logic [31:0]        CFG_F1L;
  logic [13:0]        CFG_PTW1;
  logic [2:0]         CFG_MODE;
  logic [AW-1:0]      CUR_IDX;

  int checks = 0, failures = 0;
  ev_t exp_q[$];
  logic [47:0] m_ftw [DEPTH];
  logic [13:0] m_ptw [DEPTH];
  int          m_dwell [DEPTH];
  int ready_dly = 90;
  bit ready_en = 1'b1;
  int ioud_falls = 0;

  dds_hop_scheduler #(.DEPTH(DEPTH), .AW(AW), .DWELL_W(DWELL_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTN(RSTN), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_FTW(TBL_FTW),
    .TBL_PTW(TBL_PTW), .TBL_DWELL(TBL_DWELL), .START(START), .STOP(STOP), .NUM(NUM),
    .LOOP(LOOP), .CFG_CEN(CFG_CEN), .CFG_F1H(CFG_F1H), .CFG_F1L(CFG_F1L),
    .CFG_PTW1(CFG_PTW1), .CFG_MODE(CFG_MODE), .CFG_READY(CFG_READY), .IOUD(IOUD),
    .BUSY(BUSY), .CUR_IDX(CUR_IDX), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference model: entry k of a run is table[k mod n]; the gap before it is
  // the previous entry's dwell, never shorter than 16 cycles.
  function automatic int gap_of(input int d);
    return (d < 16) ? 16 : d;
  endfunction

  function automatic void push_seq(input int k0, input int cnt, input int n);
    for (int k = k0; k < k0 + cnt; k++) begin
      ev_t e;
      e.kind = EV_CEN;
      e.idx  = k % n;
      e.ftw  = m_ftw[k % n];
      e.ptw  = m_ptw[k % n];
      e.gap  = (k == 0) ? -1 : gap_of(m_dwell[(k - 1) % n]);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void push_ev(input int kind);
    ev_t e;
    e.kind = kind; e.idx = 0; e.ftw = '0; e.ptw = '0; e.gap = -1;
    exp_q.push_back(e);
  endfunction

  // Writer model: READY pulses ready_dly cycles after CEN rises.
  initial begin
    int wcnt;
    wcnt = 0;
    CFG_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      CFG_READY = 1'b0;
      if (CFG_CEN) begin
        wcnt++;
        if (ready_en && wcnt == ready_dly) CFG_READY = 1'b1;
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : monitor
    ev_t e;
    int cyc, cen_rise, cen_len, ioud_len, ioud_fall;
    logic cen_p, err_p, ioud_p, busy_p, rdy_p;
    logic [47:0] cur_ftw;
    cyc = 0; cen_rise = 0; cen_len = 0; ioud_len = 0; ioud_fall = 0;
    cen_p = 0; err_p = 0; ioud_p = 0; busy_p = 0; rdy_p = 0; cur_ftw = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RSTN) begin
        if (CFG_CEN && !cen_p) begin
          cen_rise = cyc;
          chk("unexpected_cen", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur_ftw = e.ftw;
            chk("cen_kind", 64'(e.kind), 64'(EV_CEN));
            chk("cen_idx", 64'(CUR_IDX), 64'(e.idx));
            chk("cen_ftw", 64'({CFG_F1H, CFG_F1L}), 64'(e.ftw));
            chk("cen_ptw", 64'(CFG_PTW1), 64'(e.ptw));
            if (e.gap >= 0) chk("cen_gap", 64'(cyc - ioud_fall), 64'(e.gap));
          end
        end
        if (!CFG_CEN && cen_p) begin
          cen_len = cyc - cen_rise;
          chk("cen_hold_ftw", 64'({CFG_F1H, CFG_F1L}), 64'(cur_ftw));
        end
        if (ERR && !err_p) begin
          chk("unexpected_err", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("err_kind", 64'(e.kind), 64'(EV_ERR));
            chk("err_cen_len", 64'(cen_len), 64'(TIMEOUT));
            chk("err_busy", 64'(BUSY), 64'(0));
          end
        end
        if (DONE) begin
          chk("unexpected_done", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_kind", 64'(e.kind), 64'(EV_DONE));
            chk("done_busy", 64'({busy_p, BUSY}), 64'(2'b10));
          end
        end
        if (IOUD && !ioud_p) chk("ioud_after_ready", 64'(rdy_p), 64'(1));
        if (IOUD) ioud_len++;
        if (!IOUD && ioud_p) begin
          chk("ioud_width", 64'(ioud_len), 64'(2));
          ioud_len = 0;
          ioud_fall = cyc;
          ioud_falls++;
        end
      end else begin
        ioud_len = 0;
      end
      cen_p = CFG_CEN; err_p = ERR; ioud_p = IOUD; busy_p = BUSY; rdy_p = CFG_READY;
    end
  end

  task automatic write_entry(input int idx, input logic [47:0] f, input logic [13:0] p, input int d);
    @(posedge CLK); #1;
    TBL_WE = 1'b1; TBL_ADDR = AW'(idx); TBL_FTW = f; TBL_PTW = p; TBL_DWELL = DWELL_W'(d);
    m_ftw[idx] = f; m_ptw[idx] = p; m_dwell[idx] = d;
    @(posedge CLK); #1;
    TBL_WE = 1'b0;
  endtask

  task automatic pulse(input bit s_start, input bit s_stop);
    @(posedge CLK); #1;
    START = s_start; STOP = s_stop;
    @(posedge CLK); #1;
    START = 1'b0; STOP = 1'b0;
  endtask

  task automatic start_seq(input string tag);
    pulse(1'b1, 1'b0);
    @(negedge CLK);
    chk({tag, "_start_cen"}, 64'(CFG_CEN), 64'(1));
    chk({tag, "_start_busy"}, 64'(BUSY), 64'(1));
    chk({tag, "_start_err"}, 64'(ERR), 64'(0));
  endtask

  task automatic wait_falls(input int target, input int limit);
    int n;
    n = 0;
    while (ioud_falls < target && n < limit) begin @(negedge CLK); n++; end
    chk("wait_ioud", 64'(ioud_falls >= target), 64'(1));
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < limit) begin @(negedge CLK); n++; end
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_idle"}, 64'(BUSY), 64'(0));
    exp_q.delete();
    repeat (5) @(negedge CLK);
  endtask

  initial begin : stim
    int fb, nv, neff, k;
    RSTN = 1'b0; START = 1'b0; STOP = 1'b0; TBL_WE = 1'b0; TBL_ADDR = '0;
    TBL_FTW = '0; TBL_PTW = '0; TBL_DWELL = '0; NUM = '0; LOOP = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cen", 64'(CFG_CEN), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_ioud", 64'(IOUD), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_err", 64'(ERR), 64'(0));
    chk("rst_idx", 64'(CUR_IDX), 64'(0));
    chk("rst_cfg", 64'({CFG_F1H, CFG_F1L, CFG_PTW1}), 64'(0));
    chk("rst_mode", 64'(CFG_MODE), 64'(0));
    @(posedge CLK); #1 RSTN = 1'b1;

    // Three-entry single pass, with a START ignored mid-sequence.
    write_entry(0, 48'h0000_1000_0000, 14'h0011, 100);
    write_entry(1, 48'h0000_2000_0000, 14'h0022, 100);
    write_entry(2, 48'h0000_3000_0000, 14'h0033, 100);
    NUM = 4'd3; LOOP = 1'b0; ready_dly = 90;
    fb = ioud_falls;
    push_seq(0, 3, 3); push_ev(EV_DONE);
    start_seq("seq3");
    wait_falls(fb + 1, 400);
    repeat (5) @(negedge CLK);
    pulse(1'b1, 1'b0);
    wait_idle("seq3", 2000);

    // Looping run stopped during the second entry-1 dwell.
    LOOP = 1'b1;
    fb = ioud_falls;
    push_seq(0, 5, 3); push_ev(EV_DONE);
    start_seq("loop");
    wait_falls(fb + 5, 2000);
    repeat (10) @(negedge CLK);
    pulse(1'b0, 1'b1);
    wait_idle("loop_stop", 100);
    repeat (250) @(negedge CLK);
    chk("no_cen_after_stop", 64'(CFG_CEN), 64'(0));
    LOOP = 1'b0;

    // Dwell shorter than the minimum gap.
    write_entry(0, 48'h0000_0ABC_DEF0, 14'h0101, 3);
    write_entry(1, 48'h0000_0123_4567, 14'h0202, 3);
    NUM = 4'd2; ready_dly = 10;
    push_seq(0, 2, 2); push_ev(EV_DONE);
    start_seq("mingap");
    wait_idle("mingap", 500);

    // READY never returned: timeout, then the next START clears ERR.
    ready_en = 1'b0; NUM = 4'd1;
    push_seq(0, 1, 1); push_ev(EV_ERR);
    start_seq("tmo");
    wait_idle("tmo", 400);
    chk("tmo_err_sticky", 64'(ERR), 64'(1));
    ready_en = 1'b1; ready_dly = 20;
    push_seq(0, 1, 1); push_ev(EV_DONE);
    start_seq("after_tmo");
    wait_idle("after_tmo", 400);

    // NUM=0 ignored; STOP alone in IDLE ignored; START+STOP together runs.
    NUM = 4'd0;
    pulse(1'b1, 1'b0);
    repeat (20) @(negedge CLK);
    chk("num0_busy", 64'(BUSY), 64'(0));
    chk("num0_cen", 64'(CFG_CEN), 64'(0));
    pulse(1'b0, 1'b1);
    NUM = 4'd2;
    push_seq(0, 2, 2); push_ev(EV_DONE);
    pulse(1'b1, 1'b1);
    @(negedge CLK);
    chk("start_stop_busy", 64'(BUSY), 64'(1));
    wait_idle("start_stop", 500);

    // Reset while entry 1 waits for READY.
    write_entry(0, 48'h0000_1111_0000, 14'h0A0A, 20);
    write_entry(1, 48'h0000_2222_0000, 14'h0B0B, 20);
    NUM = 4'd3; ready_dly = 15;
    fb = ioud_falls;
    push_seq(0, 2, 3);
    start_seq("rst_load");
    wait_falls(fb + 1, 200);
    ready_dly = 200;
    repeat (30) @(negedge CLK);
    chk("rst_load_cen_before", 64'(CFG_CEN), 64'(1));
    @(posedge CLK); #1 RSTN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_load_cen", 64'(CFG_CEN), 64'(0));
    chk("rst_load_busy", 64'(BUSY), 64'(0));
    chk("rst_load_ioud", 64'(IOUD), 64'(0));
    chk("rst_load_idx", 64'(CUR_IDX), 64'(0));
    @(posedge CLK); #1 RSTN = 1'b1;
    chk("rst_load_drain", 64'(exp_q.size()), 64'(0));
    exp_q.delete();

    // Rewrite entry 1 while entry 0 dwells.
    write_entry(0, 48'h0000_4444_0000, 14'h0C0C, 100);
    write_entry(1, 48'h0000_5555_0000, 14'h0D0D, 30);
    NUM = 4'd2; ready_dly = 30;
    fb = ioud_falls;
    push_seq(0, 1, 2);
    start_seq("rewrite");
    wait_falls(fb + 1, 300);
    repeat (5) @(negedge CLK);
    write_entry(1, 48'h0000_6666_7777, 14'h0E0E, 40);
    push_seq(1, 1, 2); push_ev(EV_DONE);
    wait_idle("rewrite", 600);

    // Randomized tables, entry counts, READY latency and looping stops.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, 48'({$urandom(), $urandom()}), 14'($urandom()), $urandom_range(0, 40));
      NUM = (AW+1)'($urandom_range(1, 15));
      nv = int'(NUM);
      neff = (nv > DEPTH) ? DEPTH : nv;
      ready_dly = $urandom_range(1, 60);
      LOOP = r[0];
      fb = ioud_falls;
      k = LOOP ? neff + $urandom_range(1, 3) : neff;
      push_seq(0, k, neff); push_ev(EV_DONE);
      start_seq("rand");
      if (LOOP) begin
        wait_falls(fb + k, 3000);
        pulse(1'b0, 1'b1);
      end
      wait_idle("rand", 3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_hop_scheduler.md
Name: dds_hop_scheduler

Overview:
Frequency-hop sequencer sitting in front of the DDS parallel-port configuration writer (single-tone mode). Holds a small host-written profile table of frequency word, phase word and dwell time per entry. On START it feeds each entry to the writer through its CEN/READY handshake, then pulses the DDS external update clock (IOUD). It dwells for that entry's time, then advances to the next entry, optionally looping.

Parameters:
DEPTH, 8, number of profile entries (power of 2)
AW, 3, table address width, log2(DEPTH)
DWELL_W, 24, dwell counter width (CLK cycles)
TIMEOUT, 255, max CLK cycles from CEN rise to READY before error

Ports:
CLK  in  1  system clock
RSTN  in  1  synchronous active-low reset
TBL_WE  in  1  table write strobe
TBL_ADDR  in  AW  table write address
TBL_FTW  in  48  frequency tuning word for entry
TBL_PTW  in  14  phase word for entry
TBL_DWELL  in  DWELL_W  dwell cycles for entry
START  in  1  begin sequence at entry 0 (pulse)
STOP  in  1  stop request (pulse)
NUM  in  AW+1  number of active entries, 1..DEPTH
LOOP  in  1  1 = wrap to entry 0 after last
CFG_CEN  out  1  enable to configuration writer
CFG_F1H  out  16  FTW[47:32] to writer
CFG_F1L  out  32  FTW[31:0] to writer
CFG_PTW1  out  14  phase word to writer
CFG_MODE  out  3  writer mode, constant 3'b000
CFG_READY  in  1  writer done pulse
IOUD  out  1  DDS update clock
BUSY  out  1  sequence active
CUR_IDX  out  AW  entry currently loaded or dwelling
DONE  out  1  one-cycle pulse at sequence end
ERR  out  1  sticky READY-timeout flag

Behaviour:
- Reset (RSTN=0 at CLK edge): state IDLE, all outputs 0 except CFG_MODE=3'b000. Table contents are not reset.
- Table write: registered on TBL_WE, allowed at any time. If a write and a fetch hit the same address in the same cycle, the fetch gets the old data.
- States: IDLE, LOAD, UPD, DWELL.
- IDLE: START with BUSY=0 and NUM!=0 -> fetch entry 0 into CFG_F1H/F1L/PTW1 registers, clear ERR, idx=0, go LOAD.
  - NUM>DEPTH is clamped to DEPTH.
  - START with NUM=0 is ignored.
- Cycle timing: START sampled at edge t -> CFG fields valid and CFG_CEN=1, BUSY=1 from t+1.
- LOAD: CFG_CEN=1. CFG_F1H/F1L/PTW1 stay stable for the whole LOAD. A timeout counter counts up from 0.
  - CFG_READY=1 -> CFG_CEN=0 next cycle, go UPD.
  - Counter reaches TIMEOUT without READY -> ERR=1, CFG_CEN=0, BUSY=0, go IDLE. No IOUD and no DONE.
- UPD: IOUD=1 for exactly 2 cycles (t_r+1, t_r+2 where t_r is the READY edge). Then load dwell counter with max(TBL_DWELL, MIN_GAP=16) and go DWELL.
  - MIN_GAP guarantees CEN stays low long enough for the writer to return to idle. The writer re-triggers if CEN is still high at its end.
- DWELL: count down to 1, then:
  - idx != last (NUM-1): idx+1.
  - idx == last and LOOP=1: idx=0.
  - Either case: fetch the entry, go LOAD.
  - idx == last and LOOP=0: DONE=1 for one cycle, BUSY=0, go IDLE.
- STOP: latched into stop_req in any state.
  - In LOAD/UPD the current entry completes, including IOUD.
  - In DWELL, stop_req exits immediately: DONE pulse, IDLE, stop_req cleared.
  - STOP in IDLE is cleared, no effect.
  - STOP and START in the same IDLE cycle: START wins.
- START while BUSY: ignored.
- CUR_IDX follows idx; it holds its last value in IDLE.
- Mid-operation reset: abort the sequence, CFG_CEN drops the next cycle. The writer finishes its own cycle independently.

Decomposition:
- Package dds_hop_pkg:
  - state encoding (IDLE/LOAD/UPD/DWELL)
  - MIN_GAP=16, IOUD_W=2, MODE_SINGLE=3'b000
  - entry field widths (FTW 48, PTW 14)
- Sub-module dds_hop_table: DEPTH x (48+14+DWELL_W) register array, one write port, combinational read. The scheduler registers the read into the CFG outputs.

Test Plan:
- Write entries 0..2 (FTW 48'h0000_1000_0000, 48'h0000_2000_0000, 48'h0000_3000_0000; dwell 100), NUM=3, LOOP=0, START. Model READY 90 cycles after CEN rise -> 3 CEN windows with those FTWs in order, 2-cycle IOUD 1 cycle after each READY, DONE once, BUSY falls with DONE.
- Same setup with LOOP=1 -> entry 0 FTW reappears after entry 2. Assert STOP during the second entry-1 dwell -> dwell aborts, DONE pulse, no further CEN.
- Dwell=3 -> gap between IOUD fall and next CEN rise is 16 cycles, not 3.
- READY never returned -> CEN held 255 cycles, then ERR=1, BUSY=0, no IOUD, no DONE. Next START clears ERR.
- START with NUM=0 -> no activity. START while BUSY -> ignored, sequence unaffected.
- RSTN low during LOAD -> next cycle CEN=0, BUSY=0, IOUD=0, CUR_IDX=0. Rewrite entry 1 during entry-0 dwell -> new FTW is used for entry 1.
